// File: rtl/bp_be_stride_detector.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_stride_detector
//  Purpose  : Snoops the committed load stream, learns per-PC constant
//             positive strides in a small fully-associative table, and
//             issues one striding-load request (pc, loop count, next
//             effective address, stride) once a PC is confident. Requests
//             feed the BE prefetch generator over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i           in   1               clock
//    reset_n_i       in   1               synchronous active-low reset
//    v_i             in   1               committed load valid (never stalled)
//    pc_i            in   vaddr_width_p   load PC
//    eff_addr_i      in   vaddr_width_p   load effective address
//    v_o             out  1               striding-load request valid
//    ready_and_i     in   1               consumer ready (transfer = v_o & ready_and_i)
//    pc_o            out  vaddr_width_p   request PC
//    loop_counter_o  out  loop_range_p    prefetch count (degree_p)
//    eff_addr_o      out  vaddr_width_p   first prefetch address
//    stride_o        out  stride_width_p  stride in bytes
// ============================================================================
module bp_be_stride_detector #(
    parameter int bp_params_p      = 0,   // e_bp_default_cfg
    parameter int entries_p        = 8,
    parameter int loop_range_p     = 8,
    parameter int stride_width_p   = 8,
    parameter int conf_threshold_p = 2,
    parameter int degree_p         = 4,
    // Every processor configuration in this build uses SV39 virtual addresses.
    localparam int vaddr_width_p   = (bp_params_p == 0) ? 39 : 39
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic                      v_i,
    input  logic [vaddr_width_p-1:0]  pc_i,
    input  logic [vaddr_width_p-1:0]  eff_addr_i,

    output logic                      v_o,
    input  logic                      ready_and_i,
    output logic [vaddr_width_p-1:0]  pc_o,
    output logic [loop_range_p-1:0]   loop_counter_o,
    output logic [vaddr_width_p-1:0]  eff_addr_o,
    output logic [stride_width_p-1:0] stride_o
);

    localparam int                    c_IDX_W    = $clog2(entries_p);
    localparam logic [1:0]            c_CONF_THR = 2'(conf_threshold_p);
    localparam logic [1:0]            c_CONF_MAX = 2'd3;
    localparam logic [loop_range_p-1:0] c_DEGREE = loop_range_p'(degree_p);

    // ------------------------------------------------------------------
    // Reference table
    // ------------------------------------------------------------------
    logic                      r_valid  [entries_p];
    logic [vaddr_width_p-1:0]  r_pc     [entries_p];
    logic [vaddr_width_p-1:0]  r_last   [entries_p];
    logic [stride_width_p-1:0] r_stride [entries_p];
    logic [1:0]                r_conf   [entries_p];
    logic [loop_range_p-1:0]   r_gap    [entries_p];
    logic [c_IDX_W-1:0]        r_ptr;

    // Output buffer
    logic                      r_v;
    logic [vaddr_width_p-1:0]  r_pc_o;
    logic [loop_range_p-1:0]   r_loop_o;
    logic [vaddr_width_p-1:0]  r_eff_o;
    logic [stride_width_p-1:0] r_stride_o;

    // ------------------------------------------------------------------
    // Combinational lookup; PCs are unique in the table, so at most one
    // entry can match and the priority of the loop is irrelevant.
    // ------------------------------------------------------------------
    logic               w_hit;
    logic [c_IDX_W-1:0] w_hit_idx;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < entries_p; i++) begin
            if (r_valid[i] && (r_pc[i] == pc_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = c_IDX_W'(i);
            end
        end
    end

    logic [vaddr_width_p-1:0]  w_delta;
    logic                      w_legal;
    logic                      w_match;
    logic [stride_width_p-1:0] w_stride_cur;
    logic [1:0]                w_conf_cur;
    logic [loop_range_p-1:0]   w_gap_cur;
    logic [1:0]                w_conf_nxt;
    logic [stride_width_p-1:0] w_stride_nxt;
    logic [loop_range_p-1:0]   w_gap_nxt;
    logic                      w_trigger;
    logic                      w_load;

    always_comb begin
        w_stride_cur = r_stride[w_hit_idx];
        w_conf_cur   = r_conf[w_hit_idx];
        w_gap_cur    = r_gap[w_hit_idx];

        // Unsigned difference: a backwards step wraps to a huge value and
        // is rejected by the upper-bits check just like an oversized step.
        w_delta = eff_addr_i - r_last[w_hit_idx];
        w_legal = (w_delta != '0)
               && (w_delta[vaddr_width_p-1:stride_width_p] == '0);
        w_match = w_legal && (w_delta[stride_width_p-1:0] == w_stride_cur);

        if (!w_match) begin
            w_conf_nxt = 2'd0;
        end else if (w_conf_cur == c_CONF_MAX) begin
            w_conf_nxt = c_CONF_MAX;
        end else begin
            w_conf_nxt = w_conf_cur + 2'd1;
        end

        w_stride_nxt = w_legal ? w_delta[stride_width_p-1:0] : '0;

        w_trigger = v_i && w_hit && w_match
                 && (w_conf_nxt >= c_CONF_THR) && (w_gap_cur == '0);
        w_load    = w_trigger && (!r_v || ready_and_i);

        // A dropped trigger leaves gap at zero so the next match retries.
        if (!w_match) begin
            w_gap_nxt = '0;
        end else if (w_load) begin
            w_gap_nxt = c_DEGREE;
        end else if (w_gap_cur != '0) begin
            w_gap_nxt = w_gap_cur - 1'b1;
        end else begin
            w_gap_nxt = w_gap_cur;
        end
    end

    // ------------------------------------------------------------------
    // Table valid bits and round-robin allocation pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < entries_p; i++) begin
                r_valid[i] <= 1'b0;
            end
            r_ptr <= '0;
        end else if (v_i && !w_hit) begin
            r_valid[r_ptr] <= 1'b1;
            r_ptr          <= r_ptr + c_IDX_W'(1);
        end
    end

    // Table payload; only meaningful under a set valid bit, so no reset.
    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_hit) begin
                r_last[w_hit_idx]   <= eff_addr_i;
                r_stride[w_hit_idx] <= w_stride_nxt;
                r_conf[w_hit_idx]   <= w_conf_nxt;
                r_gap[w_hit_idx]    <= w_gap_nxt;
            end else begin
                r_pc[r_ptr]     <= pc_i;
                r_last[r_ptr]   <= eff_addr_i;
                r_stride[r_ptr] <= '0;
                r_conf[r_ptr]   <= 2'd0;
                r_gap[r_ptr]    <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Single-entry output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_v        <= 1'b0;
            r_pc_o     <= '0;
            r_loop_o   <= '0;
            r_eff_o    <= '0;
            r_stride_o <= '0;
        end else if (w_load) begin
            r_v        <= 1'b1;
            r_pc_o     <= pc_i;
            r_loop_o   <= c_DEGREE;
            r_eff_o    <= eff_addr_i + vaddr_width_p'(w_stride_cur);
            r_stride_o <= w_stride_cur;
        end else if (ready_and_i) begin
            r_v        <= 1'b0;
        end
    end

    assign v_o            = r_v;
    assign pc_o           = r_pc_o;
    assign loop_counter_o = r_loop_o;
    assign eff_addr_o     = r_eff_o;
    assign stride_o       = r_stride_o;

endmodule
`default_nettype wire

// File: tb/tb_bp_be_stride_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_be_stride_detector
//  Purpose  : Directed-vector scoreboard bench for bp_be_stride_detector.
//             Stimulus pushes hand-computed requests; an independent
//             monitor checks presentation cycle, hold stability and the
//             transferred fields.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_be_stride_detector;

    localparam int c_VW = 39;
    localparam int c_LR = 8;
    localparam int c_SW = 8;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic            v_i;
    logic [c_VW-1:0] pc_i;
    logic [c_VW-1:0] eff_addr_i;
    logic            v_o;
    logic            ready_and_i;
    logic [c_VW-1:0] pc_o;
    logic [c_LR-1:0] loop_counter_o;
    logic [c_VW-1:0] eff_addr_o;
    logic [c_SW-1:0] stride_o;

    bp_be_stride_detector dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .v_i            (v_i),
        .pc_i           (pc_i),
        .eff_addr_i     (eff_addr_i),
        .v_o            (v_o),
        .ready_and_i    (ready_and_i),
        .pc_o           (pc_o),
        .loop_counter_o (loop_counter_o),
        .eff_addr_o     (eff_addr_o),
        .stride_o       (stride_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [c_VW-1:0] pc;
        logic [c_VW-1:0] addr;
        logic [c_SW-1:0] stride;
        logic [c_LR-1:0] cnt;
        int              cyc;
    } req_t;

    req_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic            prev_v    = 1'b0;
    logic            prev_xfer = 1'b0;
    logic [c_VW-1:0] h_pc, h_addr;
    logic [c_SW-1:0] h_stride;
    logic [c_LR-1:0] h_cnt;
    req_t            mon_e;

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (v_o === 1'b1) begin
                if (!prev_v || prev_xfer) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_request: got pc 0x%0h addr 0x%0h, expected none",
                                 pc_o, eff_addr_o);
                    end else begin
                        check("issue_cycle", 64'(cyc), 64'(exp_q[0].cyc));
                    end
                end else begin
                    check("hold_pc",     pc_o,           h_pc);
                    check("hold_addr",   eff_addr_o,     h_addr);
                    check("hold_stride", stride_o,       h_stride);
                    check("hold_cnt",    loop_counter_o, h_cnt);
                end
                h_pc     = pc_o;
                h_addr   = eff_addr_o;
                h_stride = stride_o;
                h_cnt    = loop_counter_o;
                if (ready_and_i === 1'b1 && exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("req_pc",     pc_o,           mon_e.pc);
                    check("req_addr",   eff_addr_o,     mon_e.addr);
                    check("req_stride", stride_o,       mon_e.stride);
                    check("req_cnt",    loop_counter_o, mon_e.cnt);
                end
            end
            prev_v    = (v_o === 1'b1);
            prev_xfer = (v_o === 1'b1) && (ready_and_i === 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic ld(input logic [c_VW-1:0] pc, input logic [c_VW-1:0] a);
        @(posedge clk_i); #1;
        v_i        = 1'b1;
        pc_i       = pc;
        eff_addr_i = a;
    endtask

    // Load that must trigger a request with the given next address/stride.
    task automatic ld_trig(input logic [c_VW-1:0] pc, input logic [c_VW-1:0] a,
                           input logic [c_VW-1:0] exp_addr, input logic [c_SW-1:0] exp_stride);
        req_t e;
        ld(pc, a);
        e.pc     = pc;
        e.addr   = exp_addr;
        e.stride = exp_stride;
        e.cnt    = 8'd4;
        e.cyc    = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
            v_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_v_o",      v_o,            0);
        check("rst_pc_o",     pc_o,           0);
        check("rst_eff_addr", eff_addr_o,     0);
        check("rst_stride",   stride_o,       0);
        check("rst_loop_cnt", loop_counter_o, 0);
        reset_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset_n_i   = 1'b0;
        v_i         = 1'b0;
        pc_i        = '0;
        eff_addr_i  = '0;
        ready_and_i = 1'b1;
        do_reset();
        mon_en = 1'b1;

        // Stride 8 on PC 0x100: trigger on 4th load, gap suppresses the next 4.
        ld(39'h100, 39'h1000);
        ld(39'h100, 39'h1008);
        ld(39'h100, 39'h1010);
        ld_trig(39'h100, 39'h1018, 39'h1020, 8'd8);
        ld(39'h100, 39'h1020);
        ld(39'h100, 39'h1028);
        ld(39'h100, 39'h1030);
        ld(39'h100, 39'h1038);
        ld_trig(39'h100, 39'h1040, 39'h1048, 8'd8);
        idle(3);

        // Negative, zero-wrapping and oversized deltas never build confidence.
        ld(39'h200, 39'h3000);
        ld(39'h200, 39'h2FF8);
        ld(39'h200, 39'h2FF0);
        ld(39'h200, 39'h4000);
        ld(39'h200, 39'h4400);
        ld(39'h200, 39'h4408);
        ld(39'h200, 39'h4410);
        idle(3);

        // Nine distinct PCs into eight entries, then revisit the first.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            ld(39'h400 + 39'(i * 16), 39'h8000 + 39'(i * 256));
            ld(39'h400 + 39'(i * 16), 39'h8004 + 39'(i * 256));
            ld(39'h400 + 39'(i * 16), 39'h8008 + 39'(i * 256));
        end
        ld(39'h400, 39'h800C);
        ld(39'h400, 39'h8010);
        ld(39'h400, 39'h8014);
        ld_trig(39'h400, 39'h8018, 39'h801C, 8'd4);
        ld_trig(39'h480, 39'h880C, 39'h8810, 8'd4);
        ld_trig(39'h430, 39'h830C, 39'h8310, 8'd4);
        idle(3);

        // Back-to-back triggers while stalled: second is dropped, retried later.
        ready_and_i = 1'b0;
        ld(39'h500, 39'h9000);
        ld(39'h600, 39'hA000);
        ld(39'h500, 39'h9010);
        ld(39'h600, 39'hA010);
        ld(39'h500, 39'h9020);
        ld(39'h600, 39'hA020);
        ld_trig(39'h500, 39'h9030, 39'h9040, 8'h10);
        ld(39'h600, 39'hA030);
        idle(4);
        ready_and_i = 1'b1;
        idle(2);
        ld_trig(39'h600, 39'hA040, 39'hA050, 8'h10);
        idle(3);

        // Reset with a pending request and a trained table.
        ready_and_i = 1'b0;
        ld(39'h700, 39'hB000);
        ld(39'h700, 39'hB008);
        ld(39'h700, 39'hB010);
        ld_trig(39'h700, 39'hB018, 39'hB020, 8'd8);
        idle(2);
        check("pending_before_reset", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        do_reset();
        ready_and_i = 1'b1;
        ld(39'h700, 39'hB000);
        ld(39'h700, 39'hB008);
        ld(39'h700, 39'hB010);
        ld_trig(39'h700, 39'hB018, 39'hB020, 8'd8);
        idle(4);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
